// File: rtl/sfq_toggle_rx_if.sv
// Event output stream of sfq_toggle_rx: head FIFO entry with a valid/ready handshake.
interface sfq_toggle_rx_if #(
  parameter int TS_W = 16
);
  logic            out_valid;
  logic            out_ready;
  logic [TS_W-1:0] out_ts;
  logic            out_viol;

  modport master (output out_valid, out_ts, out_viol, input out_ready);
  modport slave  (input out_valid, out_ts, out_viol, output out_ready);
endinterface

// File: rtl/sfq_toggle_rx.sv
// Toggle-encoded SFQ line receiver: synchronizes tq, turns level changes into timestamped,
// spacing-checked events and queues them in a FIFO. SFQ_RX_PULSE_CNT_EN adds pulse_cnt.
module sfq_toggle_rx #(
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tq,
  sfq_toggle_rx_if.master     out_bus,
  output logic                ovf,
  output logic                err,
  input  logic                err_clr
`ifdef SFQ_RX_PULSE_CNT_EN
  ,
  output logic [CNT_W-1:0]    pulse_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(MIN_GAP + 1);

  logic            s1, s2, s3;
  logic [TS_W-1:0] ts;
  logic [GW-1:0]   gap;
  logic            first_seen;

  logic [TS_W:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [TS_W:0]   head;

  logic evt, viol, empty, full, pop, push, drop, valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    evt   = s2 ^ s3;
    viol  = evt && first_seen && (gap < GW'(MIN_GAP));
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    valid = !empty;
    pop   = valid && out_bus.out_ready;
    // A full FIFO still accepts the event when the head leaves on the same edge.
    push  = evt && (!full || pop);
    drop  = evt && full && !pop;
    head  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      gap        <= '0;
      first_seen <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (evt) begin
        gap        <= GW'(1);
        first_seen <= 1'b1;
      end else if (gap < GW'(MIN_GAP)) begin
        gap <= gap + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {viol, ts};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sticky flags: a set on the same edge as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      ovf <= 1'b0;
    end else begin
      err <= (err && !err_clr) || viol;
      ovf <= (ovf && !err_clr) || drop;
    end
  end

`ifdef SFQ_RX_PULSE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
    end else if (evt && (pulse_cnt != '1)) begin
      pulse_cnt <= pulse_cnt + CNT_W'(1);
    end
  end
`endif

  assign out_bus.out_valid = valid;
  assign out_bus.out_ts    = valid ? head[TS_W-1:0] : '0;
  assign out_bus.out_viol  = valid ? head[TS_W] : 1'b0;

endmodule

// File: tb/tb_sfq_toggle_rx.sv
// Scoreboard bench for sfq_toggle_rx: edge-level reference model feeds an expected-entry queue.
module tb_sfq_toggle_rx;
  localparam int TS_W    = 16;
  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tq = 1'b0;
  logic err_clr = 1'b0;
  logic ovf, err;
`ifdef SFQ_RX_PULSE_CNT_EN
  logic [CNT_W-1:0] pulse_cnt;
`endif

  sfq_toggle_rx_if #(.TS_W(TS_W)) bus ();

  sfq_toggle_rx #(
    .TS_W(TS_W), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tq(tq), .out_bus(bus),
    .ovf(ovf), .err(err), .err_clr(err_clr)
`ifdef SFQ_RX_PULSE_CNT_EN
    , .pulse_cnt(pulse_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the line level seen at each clock edge since reset release.
  typedef struct { int ts; bit viol; } ent_t;
  ent_t   exp_q[$];
  bit     hist[$];
  int     edge_n = 0;
  int     last_evt = 0;
  bit     seen = 0;
  int     occ = 0;
  bit     m_err = 0, m_ovf = 0;
  longint m_cnt = 0;

  function automatic bit lvl(input int i);
    return (i < 0) ? 1'b0 : hist[i];
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    edge_n = 0; seen = 0; occ = 0;
    m_err = 0; m_ovf = 0; m_cnt = 0;
  endtask

  always @(posedge clk) begin
    bit e, v, pop;
    ent_t n;
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      // A level change on the line becomes visible as an event two edges after first sampling.
      e   = lvl(edge_n - 2) != lvl(edge_n - 3);
      pop = (occ > 0) && bus.out_ready;
      if (err_clr) begin m_err = 0; m_ovf = 0; end
      if (e) begin
        v = seen && ((edge_n - last_evt) < MIN_GAP);
        seen = 1;
        last_evt = edge_n;
        if (v) m_err = 1;
        if (m_cnt < (longint'(1) << CNT_W) - 1) m_cnt++;
        if (occ < DEPTH || pop) begin
          n.ts = edge_n % (1 << TS_W);
          n.viol = v;
          exp_q.push_back(n);
          occ++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) occ--;
      hist.push_back(tq);
      edge_n++;
    end
  end

  // Monitor: compares flags each cycle and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    ent_t x;
    if (rst_n) begin
      chk("out_valid", bus.out_valid, occ > 0);
      chk("err", err, m_err);
      chk("ovf", ovf, m_ovf);
`ifdef SFQ_RX_PULSE_CNT_EN
      chk("pulse_cnt", pulse_cnt, m_cnt);
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_entry: got ts %0d, expected no entry", bus.out_ts);
        end else begin
          x = exp_q.pop_front();
          chk("out_ts", bus.out_ts, x.ts);
          chk("out_viol", bus.out_viol, x.viol);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    step(3);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ts", bus.out_ts, 0);
    chk("rst_viol", bus.out_viol, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // first event: level change sampled at edge 10
    step(10);
    tq = 1'b1;
    step(3);
    chk("first_valid", bus.out_valid, 1);
    chk("first_ts", bus.out_ts, 12);
    chk("first_viol", bus.out_viol, 0);
    chk("first_err", err, 0);
    bus.out_ready = 1'b1;
    step(2);

    repeat (5) begin
      step(6);
      tq = ~tq;
    end
    step(8);

    // two events two cycles apart
    tq = ~tq;
    step(2);
    tq = ~tq;
    step(4);
    chk("viol_err", err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    step(4);

    repeat (1500) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 2) == 0) tq = ~tq;
      step(1);
    end
    err_clr = 1'b0;
    bus.out_ready = 1'b1;
    step(20);

    // overflow with the consumer stalled
    bus.out_ready = 1'b0;
    repeat (10) begin
      tq = ~tq;
      step(6);
    end
    step(4);
    chk("ovf_set", ovf, 1);
    chk("full_valid", bus.out_valid, 1);

    // push and pop on the same edge while full
    tq = ~tq;
    step(2);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    step(2);
    chk("full_pushpop_ovf", ovf, 1);
    chk("full_pushpop_occ", occ, DEPTH);

    bus.out_ready = 1'b1;
    step(12);
    bus.out_ready = 1'b0;
    repeat (3) begin
      tq = ~tq;
      step(5);
    end
    step(3);
    chk("burst_queued", occ, 3);

    // asynchronous reset mid-burst, line held high
    #1;
    rst_n = 1'b0;
    tq = 1'b1;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_err", err, 0);
    chk("async_ovf", ovf, 0);
`ifdef SFQ_RX_PULSE_CNT_EN
    chk("async_cnt", pulse_cnt, 0);
`endif
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_ts", bus.out_ts, 2);
    chk("post_rst_viol", bus.out_viol, 0);

    bus.out_ready = 1'b1;
    step(20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
